// File: rtl/serial_unremap.sv
// serial_unremap: inverse of the FFT even/odd serial remapper.
// Each 8-sample input block carries natural indices 0,2,4,6,1,3,5,7. The
// block is captured into one half of a 16-entry ping-pong buffer and read
// back in natural order while the other half fills.
//
// Handshake: in_valid marks a sample on input_data in that cycle, and the
// sample is always taken because there is no ready. out_valid marks a
// natural-order sample on output_data, and the downstream side must take it.
// out_first and out_last tag samples 0 and 7 of each block. None of the
// outputs can stall.
module serial_unremap #(
    // Sample width; matches the FFT pipeline sample width (FFTsfpw)
    parameter int nb = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          in_valid,
    input  logic [nb-1:0] input_data,
    output logic          out_valid,
    output logic [nb-1:0] output_data,
    output logic          out_first,
    output logic          out_last,
    output logic [0:0]    o_dbg_state
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    logic [nb-1:0] r_buf [0:15];
    logic [3:0]    r_wr_cnt;
    logic [1:0]    r_full;
    logic          r_rd_bank;
    logic [2:0]    r_j;
    logic [0:0]    r_state;

    logic          w_clear;
    logic          w_accept;
    logic [1:0]    w_set;
    logic [1:0]    w_clr;
    logic          w_read;
    logic [2:0]    w_j;
    logic [3:0]    w_rd_addr;
    logic          w_blk_done;
    logic          w_other_full;

    // Reset and start share one clearing path; both discard a same-cycle sample
    assign w_clear  = !reset_n || start;
    assign w_accept = in_valid && !w_clear;

    // Decode full-flag set/clear and the read address for this cycle
    always_comb begin
        w_set        = 2'b00;
        w_clr        = 2'b00;
        w_read       = 1'b0;
        w_j          = 3'd0;
        w_rd_addr    = 4'd0;
        w_blk_done   = 1'b0;
        w_other_full = 1'b0;
        // The 8th sample of a bank marks that bank complete
        if (w_accept && (r_wr_cnt[2:0] == 3'd7)) begin
            w_set[r_wr_cnt[3]] = 1'b1;
        end
        // From IDLE the first read happens on the same edge the flag is seen,
        // so sample 0 is registered one edge after the bank fills
        w_read = (r_state == S_DRAIN) || r_full[r_rd_bank];
        w_j    = (r_state == S_DRAIN) ? r_j : 3'd0;
        // Natural index j lives at bank offset {j[0], j[2:1]}: 0,4,1,5,2,6,3,7
        w_rd_addr  = {r_rd_bank, w_j[0], w_j[2:1]};
        w_blk_done = w_read && (w_j == 3'd7);
        if (w_blk_done) begin
            w_clr[r_rd_bank] = 1'b1;
        end
        // Include a same-edge fill of the other bank so continuous input has no bubble
        w_other_full = r_full[~r_rd_bank] | w_set[~r_rd_bank];
    end

    // Sample storage; not reset because a bank is only read once marked full
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_wr_cnt] <= input_data;
        end
    end

    // Write pointer and per-bank full flags; a set beats a clear on the same bank
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wr_cnt <= 4'd0;
            r_full   <= 2'b00;
        end else begin
            if (w_accept) begin
                r_wr_cnt <= r_wr_cnt + 4'd1;
            end
            r_full <= (r_full & ~w_clr) | w_set;
        end
    end

    // Read-side state machine and registered natural-order output
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state     <= S_IDLE;
            r_rd_bank   <= 1'b0;
            r_j         <= 3'd0;
            out_valid   <= 1'b0;
            out_first   <= 1'b0;
            out_last    <= 1'b0;
            output_data <= '0;
        end else if (w_read) begin
            output_data <= r_buf[w_rd_addr];
            out_valid   <= 1'b1;
            out_first   <= (w_j == 3'd0);
            out_last    <= (w_j == 3'd7);
            r_j         <= w_j + 3'd1;
            if (w_blk_done) begin
                r_rd_bank <= ~r_rd_bank;
                r_state   <= w_other_full ? S_DRAIN : S_IDLE;
            end else begin
                r_state <= S_DRAIN;
            end
        end else begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_unremap.sv
// Bench for serial_unremap: drives remapped blocks, models the natural-order
// stream with a block reorder on queues, and compares per scenario.
module tb_serial_unremap;

    localparam int NB = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          in_valid;
    logic [NB-1:0] input_data;
    logic          out_valid;
    logic [NB-1:0] output_data;
    logic          out_first;
    logic          out_last;
    logic [0:0]    o_dbg_state;

    typedef struct packed {
        logic          v;
        logic          f;
        logic          l;
        logic [NB-1:0] d;
    } obs_t;

    obs_t          obs_q[$];
    logic [NB-1:0] acc_q[$];
    logic [NB-1:0] exp_q[$];
    int            errors = 0;
    int            checks = 0;
    int            vals[16] = '{0, 2, 4, 6, 1, 3, 5, 7, 8, 10, 12, 14, 9, 11, 13, 15};

    serial_unremap #(.nb(NB)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .in_valid    (in_valid),
        .input_data  (input_data),
        .out_valid   (out_valid),
        .output_data (output_data),
        .out_first   (out_first),
        .out_last    (out_last),
        .o_dbg_state (o_dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // One cycle: drive inputs, update the reference model at the edge,
    // record the outputs at the following falling edge.
    task automatic drive_cycle(input logic v, input logic [NB-1:0] d,
                               input logic st, input logic rn);
        obs_t          o;
        logic [NB-1:0] blk [8];
        in_valid   = v;
        input_data = d;
        start      = st;
        reset_n    = rn;
        @(posedge clk);
        if (!rn || st) begin
            acc_q.delete();
        end else if (v) begin
            acc_q.push_back(d);
            if (acc_q.size() == 8) begin
                // position k carries natural index 2k (k<4) or 2(k-4)+1
                for (int k = 0; k < 8; k++) begin
                    blk[(k < 4) ? (2 * k) : (2 * (k - 4) + 1)] = acc_q[k];
                end
                for (int n = 0; n < 8; n++) exp_q.push_back(blk[n]);
                acc_q.delete();
            end
        end
        @(negedge clk);
        o.v = out_valid;
        o.f = out_first;
        o.l = out_last;
        o.d = output_data;
        obs_q.push_back(o);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_reset;
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, NB'($urandom), 1'b0, 1'b0);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== '0 || o_dbg_state !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: cycle %0d got v=%b f=%b l=%b d=%h, expected all 0", i, obs_q[i].v, obs_q[i].f, obs_q[i].l, obs_q[i].d);
            end
        end
        obs_q.delete();
        idle(12);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i].v !== 1'b0) begin
                errors++;
                $display("FAIL reset_quiet: cycle %0d got out_valid=%b, expected 0", i, obs_q[i].v);
            end
        end
    endtask

    task automatic test_continuous;
        int vi;
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 16; i++) drive_cycle(1'b1, NB'(vals[i]), 1'b0, 1'b1);
        idle(10);
        vi = 0;
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i].v) begin
                if (vi >= exp_q.size() || obs_q[i].d !== exp_q[vi] || obs_q[i].d !== NB'(vi) ||
                    obs_q[i].f !== (vi % 8 == 0) || obs_q[i].l !== (vi % 8 == 7)) begin
                    errors++;
                    $display("FAIL cont_data: out %0d got d=%h f=%b l=%b, expected d=%h", vi, obs_q[i].d, obs_q[i].f, obs_q[i].l, NB'(vi));
                end
                vi++;
            end else if (obs_q[i].f || obs_q[i].l) begin
                errors++;
                $display("FAIL cont_flags: cycle %0d flags f=%b l=%b while invalid, expected 0", i, obs_q[i].f, obs_q[i].l);
            end
        end
        checks++;
        if (vi != 16) begin
            errors++;
            $display("FAIL cont_count: got %0d outputs, expected 16", vi);
        end
        // last input accepted on edge 7, first output registered on edge 8
        checks++;
        if (obs_q[7].v !== 1'b0 || obs_q[8].v !== 1'b1 || obs_q[23].v !== 1'b1 || obs_q[24].v !== 1'b0) begin
            errors++;
            $display("FAIL cont_timing: valid at 7/8/23/24 = %b%b%b%b, expected 0110", obs_q[7].v, obs_q[8].v, obs_q[23].v, obs_q[24].v);
        end
    endtask

    task automatic test_gapped;
        int vi;
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            if (i % 2 == 0) drive_cycle(1'b1, NB'(vals[i / 2]), 1'b0, 1'b1);
            else            drive_cycle(1'b0, '0, 1'b0, 1'b1);
        end
        idle(10);
        vi = 0;
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i].v) begin
                if (vi >= exp_q.size() || obs_q[i].d !== exp_q[vi] ||
                    obs_q[i].f !== (vi % 8 == 0) || obs_q[i].l !== (vi % 8 == 7)) begin
                    errors++;
                    $display("FAIL gap_data: out %0d got d=%h f=%b l=%b, expected d=%h", vi, obs_q[i].d, obs_q[i].f, obs_q[i].l, NB'(vi));
                end
                vi++;
            end else if (obs_q[i].f || obs_q[i].l) begin
                errors++;
                $display("FAIL gap_flags: cycle %0d flags f=%b l=%b while invalid, expected 0", i, obs_q[i].f, obs_q[i].l);
            end
        end
        checks++;
        if (vi != 16) begin
            errors++;
            $display("FAIL gap_count: got %0d outputs, expected 16", vi);
        end
        // 8th accepted samples land on edges 14 and 30; bursts follow one edge later
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (obs_q[i].v !== ((i >= 15 && i <= 22) || (i >= 31 && i <= 38))) begin
                errors++;
                $display("FAIL gap_burst: cycle %0d got out_valid=%b", i, obs_q[i].v);
            end
        end
    endtask

    task automatic test_back_to_back;
        int vi;
        int first_i;
        int drops;
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 320; i++) drive_cycle(1'b1, NB'($urandom), 1'b0, 1'b1);
        idle(10);
        vi = 0;
        first_i = -1;
        foreach (obs_q[i]) begin
            if (obs_q[i].v) begin
                if (first_i < 0) first_i = i;
                checks++;
                if (vi >= exp_q.size() || obs_q[i].d !== exp_q[vi] ||
                    obs_q[i].f !== (vi % 8 == 0) || obs_q[i].l !== (vi % 8 == 7)) begin
                    errors++;
                    $display("FAIL b2b_data: out %0d got d=%h f=%b l=%b", vi, obs_q[i].d, obs_q[i].f, obs_q[i].l);
                end
                vi++;
            end
        end
        checks++;
        if (vi != 320 || first_i != 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d outputs starting cycle %0d, expected 320 starting 8", vi, first_i);
        end
        drops = 0;
        for (int i = 8; i < 328; i++) if (obs_q[i].v !== 1'b1) drops++;
        checks++;
        if (drops != 0) begin
            errors++;
            $display("FAIL b2b_continuous: got %0d invalid cycles inside the stream, expected 0", drops);
        end
    endtask

    task automatic test_start_discard;
        int vi;
        int bad;
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, NB'(16'hB000 | $urandom_range(0, 255)), 1'b0, 1'b1);
        drive_cycle(1'b1, NB'(16'hEEEE), 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, NB'(vals[i]), 1'b0, 1'b1);
        idle(10);
        vi = 0;
        bad = 0;
        foreach (obs_q[i]) begin
            if (obs_q[i].v) begin
                if (obs_q[i].d == NB'(16'hEEEE)) bad++;
                checks++;
                if (vi >= exp_q.size() || obs_q[i].d !== exp_q[vi] || obs_q[i].d !== NB'(vi) ||
                    obs_q[i].f !== (vi == 0) || obs_q[i].l !== (vi == 7)) begin
                    errors++;
                    $display("FAIL start_data: out %0d got d=%h f=%b l=%b, expected d=%h", vi, obs_q[i].d, obs_q[i].f, obs_q[i].l, NB'(vi));
                end
                vi++;
            end
        end
        checks++;
        if (vi != 8 || bad != 0) begin
            errors++;
            $display("FAIL start_count: got %0d outputs with %0d discarded samples, expected 8 and 0", vi, bad);
        end
    endtask

    task automatic test_reset_mid_drain;
        int vi;
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, NB'($urandom), 1'b0, 1'b1);
        idle(3);
        checks++;
        if (obs_q[obs_q.size() - 1].v !== 1'b1 || o_dbg_state !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_drain: got out_valid=%b state=%b, expected 1 and 1", obs_q[obs_q.size() - 1].v, o_dbg_state);
        end
        drive_cycle(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (obs_q[obs_q.size() - 1] !== '0 || o_dbg_state !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_drain: got v=%b f=%b l=%b d=%h state=%b, expected all 0", out_valid, out_first, out_last, output_data, o_dbg_state);
        end
        obs_q.delete();
        exp_q.delete();
        idle(4);
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, NB'($urandom), 1'b0, 1'b1);
        idle(10);
        vi = 0;
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i].v) begin
                if (vi >= exp_q.size() || obs_q[i].d !== exp_q[vi] ||
                    obs_q[i].f !== (vi == 0) || obs_q[i].l !== (vi == 7)) begin
                    errors++;
                    $display("FAIL rst_data: out %0d got d=%h f=%b l=%b", vi, obs_q[i].d, obs_q[i].f, obs_q[i].l);
                end
                vi++;
            end
        end
        checks++;
        if (vi != 8) begin
            errors++;
            $display("FAIL rst_count: got %0d outputs, expected 8", vi);
        end
    endtask

    task automatic test_wide_data;
        int vi;
        int pat[8] = '{16'hA0, 16'hA2, 16'hA4, 16'hA6, 16'hA1, 16'hA3, 16'hA5, 16'hA7};
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, NB'(pat[i]), 1'b0, 1'b1);
        idle(10);
        vi = 0;
        foreach (obs_q[i]) begin
            if (obs_q[i].v) begin
                checks++;
                if (vi >= exp_q.size() || obs_q[i].d !== exp_q[vi] || obs_q[i].d !== NB'(16'hA0 + vi)) begin
                    errors++;
                    $display("FAIL wide_data: out %0d got %h, expected %h", vi, obs_q[i].d, NB'(16'hA0 + vi));
                end
                vi++;
            end
        end
        checks++;
        if (vi != 8) begin
            errors++;
            $display("FAIL wide_count: got %0d outputs, expected 8", vi);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        in_valid   = 1'b0;
        input_data = '0;
        @(negedge clk);
        test_reset;
        test_continuous;
        test_gapped;
        test_back_to_back;
        test_start_discard;
        test_reset_mid_drain;
        test_wide_data;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
